// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage.
//   - control-word bit positions
//   - register-file input select encoding
//   - writeback FSM state encoding
//   - load classification helper
package writeback_stage_pkg;

   localparam int CW_W        = 12;
   localparam int CW_MEM_WE   = 7;
   localparam int CW_MEM_REQ  = 8;
   localparam int CW_REG_WE   = 9;
   localparam int CW_INSEL_LO = 10;
   localparam int CW_INSEL_HI = 11;

   typedef enum logic [1:0] {
      INSEL_ALU  = 2'd0,
      INSEL_UIMM = 2'd1,
      INSEL_MEM  = 2'd2,
      INSEL_PC4  = 2'd3
   } reg_insel_e;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_WAIT_MEM = 1'b1
   } wb_state_e;

   function automatic logic is_load(input logic [CW_W-1:0] cw);
      return cw[CW_MEM_REQ] & ~cw[CW_MEM_WE];
   endfunction

endpackage

// File: rtl/writeback_stage.sv
// Writeback stage: holds one op in stage register W, waits for load data when
// W holds a load, and drives the register-file write port.
//
// Ports
//   clk, rst          stage clock, async active-high reset
//   clk_en            global advance enable (low freezes all state)
//   valid_in          upstream op present
//   control_word_in   decoded control word
//   inst_in           instruction (rd, upper immediate)
//   ip_in             word address of the op
//   alu_result        execute result
//   mem_rdata         load data, qualified by mem_rvalid
//   mem_rvalid        one-cycle load-data strobe
//   stall             upstream must hold its op
//   reg_we/reg_din/rd_addr   register-file write port
//   instret           retired-op count (wraps)
//   mem_wait_cnt      cycles spent waiting for load data (saturates)
//   mem_err           sticky flag: load-data strobe with no load pending
//
// state       | meaning
// ST_RUN      | W holds a non-load or bubble; retires every enabled edge
// ST_WAIT_MEM | W holds a load; stage holds until mem_rvalid
module writeback_stage
   import writeback_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        valid_in,
   input  logic [11:0] control_word_in,
   input  logic [31:0] inst_in,
   input  logic [29:0] ip_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        stall,
   output logic        reg_we,
   output logic [31:0] reg_din,
   output logic [4:0]  rd_addr,
   output logic [31:0] instret,
   output logic [7:0]  mem_wait_cnt,
   output logic        mem_err
);

   wb_state_e  state;
   logic       w_valid;
   logic       w_reg_we;
   reg_insel_e w_insel;
   logic [4:0] w_rd;
   logic [31:0] w_alu;
   logic [29:0] w_ip;
   logic [31:0] w_uimm;

   logic retire;

   // Control bits and instruction fields this stage never looks at.
   logic unused_in_bits;
   assign unused_in_bits = ^{control_word_in[6:0], inst_in[31:21]};

   assign stall   = (state == ST_WAIT_MEM) & ~mem_rvalid;
   // A load retires only in its strobe cycle; anything else in W retires
   // on every enabled edge.
   assign retire  = clk_en & w_valid & ((state == ST_RUN) | mem_rvalid);
   assign reg_we  = retire & w_reg_we;
   assign rd_addr = w_rd;

   always_comb begin
      reg_din = w_alu;
      case (w_insel)
         INSEL_ALU:  reg_din = w_alu;
         INSEL_UIMM: reg_din = w_uimm;
         INSEL_MEM:  reg_din = mem_rdata;
         INSEL_PC4:  reg_din = {w_ip + 30'd1, 2'b00};
         default:    reg_din = w_alu;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_RUN;
         w_valid      <= 1'b0;
         w_reg_we     <= 1'b0;
         w_insel      <= INSEL_ALU;
         w_rd         <= '0;
         w_alu        <= '0;
         w_ip         <= '0;
         w_uimm       <= '0;
         instret      <= '0;
         mem_wait_cnt <= '0;
         mem_err      <= 1'b0;
      end else if (clk_en) begin
         if (retire)
            instret <= instret + 32'd1;
         if (stall && (mem_wait_cnt != 8'hFF))
            mem_wait_cnt <= mem_wait_cnt + 8'd1;
         if ((state == ST_RUN) && mem_rvalid)
            mem_err <= 1'b1;
         // W advances whenever not stalled, which includes the strobe cycle
         // so back-to-back loads see no extra bubble.
         if (!stall) begin
            w_valid  <= valid_in;
            w_reg_we <= control_word_in[CW_REG_WE];
            w_insel  <= reg_insel_e'(control_word_in[CW_INSEL_HI:CW_INSEL_LO]);
            w_rd     <= inst_in[20:16];
            w_alu    <= alu_result;
            w_ip     <= ip_in;
            w_uimm   <= {inst_in[15:0], 16'h0000};
            state    <= (valid_in && is_load(control_word_in)) ? ST_WAIT_MEM : ST_RUN;
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic        valid_in;
   logic [11:0] control_word_in;
   logic [31:0] inst_in;
   logic [29:0] ip_in;
   logic [31:0] alu_result;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        stall;
   logic        reg_we;
   logic [31:0] reg_din;
   logic [4:0]  rd_addr;
   logic [31:0] instret;
   logic [7:0]  mem_wait_cnt;
   logic        mem_err;

   writeback_stage dut (
      .clk             (clk),
      .rst             (rst),
      .clk_en          (clk_en),
      .valid_in        (valid_in),
      .control_word_in (control_word_in),
      .inst_in         (inst_in),
      .ip_in           (ip_in),
      .alu_result      (alu_result),
      .mem_rdata       (mem_rdata),
      .mem_rvalid      (mem_rvalid),
      .stall           (stall),
      .reg_we          (reg_we),
      .reg_din         (reg_din),
      .rd_addr         (rd_addr),
      .instret         (instret),
      .mem_wait_cnt    (mem_wait_cnt),
      .mem_err         (mem_err)
   );

   localparam logic [11:0] CW_ALU  = 12'h200;
   localparam logic [11:0] CW_UIMM = 12'h600;
   localparam logic [11:0] CW_PC4  = 12'hE00;
   localparam logic [11:0] CW_LOAD = 12'hB00;
   localparam logic [11:0] CW_STOR = 12'h180;

   typedef struct {
      logic [11:0] cw;
      logic [31:0] inst;
      logic [29:0] ip;
      logic [31:0] alu;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] din;
   } vec_t;

   vec_t vecs[8];
   int   n_vec = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [15:0] imm);
      return {11'd0, rd, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid_in   = 1'b0;
      mem_rvalid = 1'b0;
      clk_en     = 1'b1;
      rst        = 1'b1;
      #2;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic drive_op(input logic [11:0] cw, input logic [31:0] inst,
                           input logic [29:0] ip, input logic [31:0] alu);
      valid_in        = 1'b1;
      control_word_in = cw;
      inst_in         = inst;
      ip_in           = ip;
      alu_result      = alu;
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b1; valid_in = 1'b0; control_word_in = '0;
      inst_in = '0; ip_in = '0; alu_result = '0; mem_rdata = '0; mem_rvalid = 1'b0;

      vecs[0] = '{CW_ALU,  mk_inst(5'd5,  16'h0000), 30'h0,        32'h1234_5678, 1'b1, 5'd5,  32'h1234_5678};
      vecs[1] = '{CW_PC4,  mk_inst(5'd31, 16'h0000), 30'h3FFF_FFFF, 32'h9999_9999, 1'b1, 5'd31, 32'h0000_0000};
      vecs[2] = '{CW_UIMM, mk_inst(5'd9,  16'hABCD), 30'h0,        32'h0,         1'b1, 5'd9,  32'hABCD_0000};
      vecs[3] = '{CW_PC4,  mk_inst(5'd4,  16'h0000), 30'h10,       32'h0,         1'b1, 5'd4,  32'h0000_0044};
      vecs[4] = '{CW_STOR, mk_inst(5'd6,  16'h0000), 30'h0,        32'h0000_0055, 1'b0, 5'd6,  32'h0000_0055};
      vecs[5] = '{12'h000, mk_inst(5'd2,  16'h0000), 30'h0,        32'h0000_0077, 1'b0, 5'd2,  32'h0000_0077};
      vecs[6] = '{CW_ALU,  mk_inst(5'd0,  16'h0000), 30'h0,        32'hFFFF_FFFF, 1'b1, 5'd0,  32'hFFFF_FFFF};
      vecs[7] = '{12'h400, mk_inst(5'd1,  16'h1234), 30'h0,        32'h0,         1'b0, 5'd1,  32'h1234_0000};

      // reset state
      #3;
      chk("rst_stall",   32'(stall),        32'd0);
      chk("rst_reg_we",  32'(reg_we),       32'd0);
      chk("rst_instret", instret,           32'd0);
      chk("rst_waitcnt", 32'(mem_wait_cnt), 32'd0);
      chk("rst_mem_err", 32'(mem_err),      32'd0);
      do_reset();

      // single-cycle ops, back to back: previous op retires as the next is captured
      for (int i = 0; i < 8; i++) begin
         drive_op(vecs[i].cw, vecs[i].inst, vecs[i].ip, vecs[i].alu);
         tick();
         valid_in = 1'b0;
         #1;
         chk($sformatf("vec%0d_reg_we", i),  32'(reg_we),  32'(vecs[i].we));
         chk($sformatf("vec%0d_rd_addr", i), 32'(rd_addr), 32'(vecs[i].rd));
         chk($sformatf("vec%0d_reg_din", i), reg_din,      vecs[i].din);
         chk($sformatf("vec%0d_stall", i),   32'(stall),   32'd0);
         chk($sformatf("vec%0d_instret", i), instret,      32'(i));
      end
      tick();
      chk("vec_end_instret", instret,      32'd8);
      chk("vec_end_reg_we",  32'(reg_we),  32'd0);

      // load, data after 3 wait cycles
      do_reset();
      drive_op(CW_LOAD, mk_inst(5'd3, 16'h0), 30'h0, 32'h0);
      tick();
      valid_in = 1'b0;
      #1;
      chk("ld_c1_stall",  32'(stall),  32'd1);
      chk("ld_c1_reg_we", 32'(reg_we), 32'd0);
      tick();
      chk("ld_c2_stall",  32'(stall),  32'd1);
      tick();
      chk("ld_c3_stall",  32'(stall),  32'd1);
      chk("ld_c3_reg_we", 32'(reg_we), 32'd0);
      chk("ld_c3_waitcnt", 32'(mem_wait_cnt), 32'd2);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("ld_strobe_stall",   32'(stall),   32'd0);
      chk("ld_strobe_reg_we",  32'(reg_we),  32'd1);
      chk("ld_strobe_reg_din", reg_din,      32'hDEAD_BEEF);
      chk("ld_strobe_rd",      32'(rd_addr), 32'd3);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("ld_after_reg_we",  32'(reg_we),       32'd0);
      chk("ld_after_stall",   32'(stall),        32'd0);
      chk("ld_after_instret", instret,           32'd1);
      chk("ld_after_waitcnt", 32'(mem_wait_cnt), 32'd3);
      chk("ld_after_mem_err", 32'(mem_err),      32'd0);

      // back-to-back loads, each strobed after one wait cycle
      do_reset();
      drive_op(CW_LOAD, mk_inst(5'd1, 16'h0), 30'h0, 32'h0);
      tick();
      drive_op(CW_LOAD, mk_inst(5'd2, 16'h0), 30'h0, 32'h0);
      #1;
      chk("b2b_a_stall", 32'(stall),   32'd1);
      chk("b2b_a_rd",    32'(rd_addr), 32'd1);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      #1;
      chk("b2b_a_reg_we",  32'(reg_we),  32'd1);
      chk("b2b_a_reg_din", reg_din,      32'h1111_1111);
      chk("b2b_a_stall0",  32'(stall),   32'd0);
      tick();
      valid_in = 1'b0; mem_rvalid = 1'b0;
      #1;
      chk("b2b_b_captured_rd", 32'(rd_addr), 32'd2);
      chk("b2b_b_stall",       32'(stall),   32'd1);
      chk("b2b_b_instret",     instret,      32'd1);
      chk("b2b_b_reg_we0",     32'(reg_we),  32'd0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
      #1;
      chk("b2b_b_reg_we",  32'(reg_we),  32'd1);
      chk("b2b_b_reg_din", reg_din,      32'h2222_2222);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("b2b_end_instret", instret,           32'd2);
      chk("b2b_end_stall",   32'(stall),        32'd0);
      chk("b2b_end_waitcnt", 32'(mem_wait_cnt), 32'd2);

      // spurious strobe in RUN
      do_reset();
      clk_en = 1'b0; mem_rvalid = 1'b1;
      tick();
      chk("spur_frozen_mem_err", 32'(mem_err), 32'd0);
      clk_en = 1'b1;
      #1;
      chk("spur_reg_we", 32'(reg_we), 32'd0);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("spur_mem_err", 32'(mem_err), 32'd1);
      tick();
      tick();
      chk("spur_sticky_mem_err", 32'(mem_err), 32'd1);
      chk("spur_instret",        instret,      32'd0);

      // clk_en low during WAIT_MEM
      do_reset();
      drive_op(CW_LOAD, mk_inst(5'd8, 16'h0), 30'h0, 32'h0);
      tick();
      valid_in = 1'b0; clk_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
      #1;
      chk("frz_reg_we", 32'(reg_we), 32'd0);
      tick();
      tick();
      chk("frz_reg_we2",  32'(reg_we),       32'd0);
      chk("frz_instret",  instret,           32'd0);
      chk("frz_waitcnt",  32'(mem_wait_cnt), 32'd0);
      chk("frz_mem_err",  32'(mem_err),      32'd0);
      chk("frz_rd",       32'(rd_addr),      32'd8);
      mem_rvalid = 1'b0;
      #1;
      chk("frz_stall", 32'(stall), 32'd1);
      tick();
      chk("frz_stall2",   32'(stall),        32'd1);
      chk("frz_waitcnt2", 32'(mem_wait_cnt), 32'd0);
      clk_en = 1'b1; mem_rvalid = 1'b1;
      #1;
      chk("frz_rel_reg_we",  32'(reg_we), 32'd1);
      chk("frz_rel_reg_din", reg_din,     32'hA5A5_A5A5);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("frz_end_instret", instret,           32'd1);
      chk("frz_end_waitcnt", 32'(mem_wait_cnt), 32'd0);
      chk("frz_end_stall",   32'(stall),        32'd0);
      chk("frz_end_mem_err", 32'(mem_err),      32'd0);

      // async reset in the middle of a load wait
      do_reset();
      drive_op(CW_LOAD, mk_inst(5'd3, 16'h0), 30'h0, 32'h0);
      tick();
      valid_in = 1'b0;
      tick();
      chk("rstw_pre_waitcnt", 32'(mem_wait_cnt), 32'd1);
      chk("rstw_pre_stall",   32'(stall),        32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstw_stall",   32'(stall),        32'd0);
      chk("rstw_reg_we",  32'(reg_we),       32'd0);
      chk("rstw_waitcnt", 32'(mem_wait_cnt), 32'd0);
      chk("rstw_instret", instret,           32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      drive_op(CW_ALU, mk_inst(5'd7, 16'h0), 30'h0, 32'hCAFE_0001);
      tick();
      valid_in = 1'b0;
      #1;
      chk("rstw_alu_reg_we",  32'(reg_we),  32'd1);
      chk("rstw_alu_reg_din", reg_din,      32'hCAFE_0001);
      chk("rstw_alu_rd",      32'(rd_addr), 32'd7);
      tick();
      chk("rstw_alu_instret", instret, 32'd1);

      // wait counter saturation
      do_reset();
      drive_op(CW_LOAD, mk_inst(5'd4, 16'h0), 30'h0, 32'h0);
      tick();
      valid_in = 1'b0;
      repeat (300) tick();
      chk("sat_waitcnt", 32'(mem_wait_cnt), 32'd255);
      chk("sat_stall",   32'(stall),        32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("sat_end_waitcnt", 32'(mem_wait_cnt), 32'd255);
      chk("sat_end_instret", instret,           32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Ports use one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  in  1  stage clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 clk_en  in  1  global advance enable; low freezes all state.
REQ-005 valid_in  in  1  upstream op present.
REQ-006 control_word_in  in  12  decoded control word: bit7 MEM_WE, bit8 MEM_REQ, bit9 REG_WE, bits11:10 REG_INSEL (0 ALU, 1 UPPER_IMM, 2 MEM, 3 PC+4).
REQ-007 inst_in  in  32  instruction; rd = inst_in[20:16], upper imm = {inst_in[15:0],16'h0}.
REQ-008 ip_in  in  30  word-address of op.
REQ-009 alu_result  in  32  execute result.
REQ-010 mem_rdata  in  32  load data; mem_rvalid  in  1  one-cycle load-data strobe.
REQ-011 stall  out  1  upstream must hold its op.
REQ-012 reg_we  out  1; reg_din  out  32; rd_addr  out  5  regfile write port.
REQ-013 instret  out  32  retired-op count; mem_wait_cnt  out  8  load-wait cycles, saturating; mem_err  out  1  sticky spurious-strobe flag.

Function
REQ-014 Stage register W (valid, control word, rd, alu_result, ip, upper imm) loads from inputs on a rising edge with clk_en=1 and stall=0; valid_in=0 loads a bubble (valid=0).
REQ-015 A W op is a load when MEM_REQ=1 and MEM_WE=0.
REQ-016 FSM states RUN and WAIT_MEM; capturing a load enters WAIT_MEM; WAIT_MEM with mem_rvalid=1 and clk_en=1 returns to RUN.
REQ-017 stall = (state==WAIT_MEM) & ~mem_rvalid, combinational; stall=0 in RUN.
REQ-018 In the mem_rvalid cycle W captures the next op, so back-to-back loads incur no bubble beyond memory latency.
REQ-019 reg_we = clk_en & W.valid & REG_WE & (RUN, or WAIT_MEM with mem_rvalid=1).
REQ-020 reg_din by REG_INSEL: ALU -> alu_result; UPPER_IMM -> upper imm; MEM -> mem_rdata; PC+4 -> {ip+1, 2'b00}, 30-bit add wraps.
REQ-021 rd_addr = W.rd always; reg_we is not gated on rd=0 (regfile owns register-0 policy).
REQ-022 Stores and all-zero control words never assert reg_we or stall.
REQ-023 instret increments by 1, wrapping at 2^32, on each edge with clk_en=1 retiring a valid W op (RUN, or WAIT_MEM with mem_rvalid).
REQ-024 mem_wait_cnt increments per edge with clk_en=1, state WAIT_MEM, mem_rvalid=0; saturates at 255; never clears except reset.
REQ-025 mem_rvalid=1 in RUN with clk_en=1 is ignored for data and sets mem_err.
REQ-026 clk_en=0: no state change, reg_we=0, mem_rvalid ignored (memory holds strobe until clk_en=1).

Reset
REQ-027 rst asserted: state RUN, W.valid=0, instret=0, mem_wait_cnt=0, mem_err=0, hence reg_we=0, stall=0; takes effect immediately, including mid-WAIT_MEM (pending load dropped).

Structure
REQ-028 Shared package holds control-word bit-index localparams, REG_INSEL enum, and the FSM state enum.
REQ-029 No sub-module; mux, FSM and counters inline.

Verification
REQ-030 ALU op, rd=5, alu_result=0x1234_5678 -> next cycle reg_we=1, rd_addr=5, reg_din=0x1234_5678, instret=1.
REQ-031 Load rd=3, mem_rvalid after 3 cycles with 0xDEAD_BEEF -> stall=1 for 3 cycles, reg_we=1 only in strobe cycle with reg_din=0xDEAD_BEEF, mem_wait_cnt=3.
REQ-032 Two back-to-back loads, each strobed after 1 cycle -> second load captured in first strobe cycle, no extra bubble, instret=2.
REQ-033 PC+4 op with ip=0x3FFF_FFFF -> reg_din=0x0000_0000; UPPER_IMM inst[15:0]=0xABCD -> reg_din=0xABCD_0000.
REQ-034 Spurious mem_rvalid in RUN -> mem_err=1 sticky, no write; clk_en=0 during WAIT_MEM -> no state change, reg_we=0.
REQ-035 rst pulse mid-WAIT_MEM -> stall=0, reg_we=0, counters 0, subsequent ALU op retires normally.
